// File: rtl/aibcr3_rx_mark_align_if.sv
// Data/control bundle between the RX delay-mimic stage, the marker aligner and the core adapter.
interface aibcr3_rx_mark_align_if #(
  parameter int unsigned DWIDTH = 40,
  parameter int unsigned ERRW   = 8
);
  logic [DWIDTH-1:0] ihssi_rx_data_out_dly;
  logic              rb_align_en;
  logic              rb_err_clr;
  logic [DWIDTH-1:0] o_rx_data_aligned;
  logic              o_rx_data_vld;
  logic              o_align_lock;
  logic [5:0]        o_align_offset;
  logic [ERRW-1:0]   o_mark_err_cnt;

  modport master (
    output ihssi_rx_data_out_dly, rb_align_en, rb_err_clr,
    input  o_rx_data_aligned, o_rx_data_vld, o_align_lock, o_align_offset, o_mark_err_cnt
  );

  modport slave (
    input  ihssi_rx_data_out_dly, rb_align_en, rb_err_clr,
    output o_rx_data_aligned, o_rx_data_vld, o_align_lock, o_align_offset, o_mark_err_cnt
  );
endinterface

// File: rtl/aibcr3_rx_mark_align.sv
// RX word-marker aligner: slides a window over two consecutive words to find the "10" marker,
// qualifies lock, and presents marker-aligned words with error tracking.
module aibcr3_rx_mark_align #(
  parameter int unsigned DWIDTH   = 40,
  parameter int unsigned MARK_POS = 39,
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned ERRW     = 8
) (
  input logic                   rx_clk,
  input logic                   rx_rstn,
  aibcr3_rx_mark_align_if.slave bus
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {StHunt, StCheck, StLocked} state_e;

  state_e              state_q, state_d;
  logic [DWIDTH-1:0]   cur_q, prev_q;
  logic [DWIDTH-1:0]   data_q, data_d;
  logic                vld_q, vld_d;
  logic [5:0]          off_q, off_d;
  logic [GW-1:0]       good_q, good_d;
  logic [BW-1:0]       bad_q, bad_d;
  logic [ERRW-1:0]     err_q, err_d;

  logic [2*DWIDTH-1:0] cat;
  logic [DWIDTH-1:0]   win;
  logic                mark_ok;
  logic [5:0]          off_inc;

  always_comb begin
    cat     = {cur_q, prev_q};
    win     = DWIDTH'(cat >> off_q);
    mark_ok = win[MARK_POS] & ~win[MARK_POS-1];
    off_inc = (off_q == 6'(DWIDTH - 1)) ? 6'd0 : off_q + 6'd1;

    state_d = state_q;
    off_d   = off_q;
    good_d  = good_q;
    bad_d   = bad_q;
    err_d   = err_q;

    if (!bus.rb_align_en) begin
      // Bypass: window pinned at offset 0, hunt restarts from scratch when re-enabled.
      state_d = StHunt;
      off_d   = '0;
      good_d  = '0;
      bad_d   = '0;
    end else begin
      unique case (state_q)
        StHunt: begin
          if (mark_ok) begin
            if (LOCK_CNT == 1) begin
              state_d = StLocked;
              bad_d   = '0;
            end else begin
              state_d = StCheck;
              good_d  = GW'(1);
            end
          end else begin
            off_d = off_inc;
          end
        end
        StCheck: begin
          if (mark_ok) begin
            good_d = good_q + GW'(1);
            if (good_q + GW'(1) == GW'(LOCK_CNT)) begin
              state_d = StLocked;
              bad_d   = '0;
            end
          end else begin
            state_d = StHunt;
            good_d  = '0;
            off_d   = off_inc;
          end
        end
        StLocked: begin
          if (mark_ok) begin
            bad_d = '0;
          end else begin
            if (err_q != '1) err_d = err_q + ERRW'(1);
            bad_d = bad_q + BW'(1);
            // Offset is kept so the re-hunt starts from the last good alignment.
            if (bad_q + BW'(1) == BW'(LOSS_CNT)) begin
              state_d = StHunt;
              good_d  = '0;
              bad_d   = '0;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end

    if (bus.rb_err_clr) err_d = '0;

    data_d = win;
    vld_d  = (state_d == StLocked) || !bus.rb_align_en;
  end

  always_ff @(posedge rx_clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      state_q <= StHunt;
      cur_q   <= '0;
      prev_q  <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      off_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= bus.ihssi_rx_data_out_dly;
      prev_q  <= cur_q;
      data_q  <= data_d;
      vld_q   <= vld_d;
      off_q   <= off_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_rx_data_aligned = data_q;
  assign bus.o_rx_data_vld     = vld_q;
  assign bus.o_align_lock      = (state_q == StLocked);
  assign bus.o_align_offset    = off_q;
  assign bus.o_mark_err_cnt    = err_q;

endmodule

// File: tb/tb_aibcr3_rx_mark_align.sv
// Directed + randomized bench for the RX marker aligner, checked against a bitstream-level model.
module tb_aibcr3_rx_mark_align;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  aibcr3_rx_mark_align_if #(.DWIDTH(40), .ERRW(8)) bus8 ();
  aibcr3_rx_mark_align_if #(.DWIDTH(40), .ERRW(2)) bus2 ();

  assign bus2.ihssi_rx_data_out_dly = bus8.ihssi_rx_data_out_dly;
  assign bus2.rb_align_en           = bus8.rb_align_en;
  assign bus2.rb_err_clr            = bus8.rb_err_clr;

  aibcr3_rx_mark_align #(.ERRW(8)) u_dut (
    .rx_clk  (clk),
    .rx_rstn (rstn),
    .bus     (bus8)
  );

  aibcr3_rx_mark_align #(.ERRW(2)) u_dut_e2 (
    .rx_clk  (clk),
    .rx_rstn (rstn),
    .bus     (bus2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: a 40-bit window over an 80-bit history, lock after 8 good in a row,
  // unlock after 4 bad in a row.
  logic [39:0] m_cur, m_prev, m_data;
  logic        m_vld, m_lock;
  int          m_off, m_streak, m_bad, m_err, m_err2;
  logic [39:0] hist[$];
  logic [39:0] orig[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_cur = '0; m_prev = '0; m_data = '0; m_vld = 1'b0; m_lock = 1'b0;
    m_off = 0; m_streak = 0; m_bad = 0; m_err = 0; m_err2 = 0;
  endtask

  task automatic model_step(input logic [39:0] din, input logic en, input logic clr);
    logic [79:0] sh;
    logic [39:0] win;
    logic        ok;
    sh  = {m_cur, m_prev} >> m_off;
    win = sh[39:0];
    ok  = win[39] && !win[38];
    m_data = win;
    if (!en) begin
      m_lock = 1'b0; m_off = 0; m_streak = 0; m_bad = 0;
    end else if (!m_lock) begin
      if (ok) begin
        m_streak++;
        if (m_streak == 8) begin m_lock = 1'b1; m_bad = 0; end
      end else begin
        m_streak = 0;
        m_off = (m_off + 1) % 40;
      end
    end else begin
      if (ok) m_bad = 0;
      else begin
        if (m_err < 255) m_err++;
        if (m_err2 < 3) m_err2++;
        m_bad++;
        if (m_bad == 4) begin m_lock = 1'b0; m_streak = 0; m_bad = 0; end
      end
    end
    if (clr) begin m_err = 0; m_err2 = 0; end
    m_vld  = m_lock || !en;
    m_prev = m_cur;
    m_cur  = din;
  endtask

  task automatic check_all();
    chk("data", 64'(bus8.o_rx_data_aligned), 64'(m_data));
    chk("vld", 64'(bus8.o_rx_data_vld), 64'(m_vld));
    chk("lock", 64'(bus8.o_align_lock), 64'(m_lock));
    chk("offset", 64'(bus8.o_align_offset), 64'(m_off));
    chk("err_cnt", 64'(bus8.o_mark_err_cnt), 64'(m_err));
    chk("err_cnt_w2", 64'(bus2.o_mark_err_cnt), 64'(m_err2));
  endtask

  task automatic step(input logic [39:0] din, input logic en, input logic clr);
    bus8.ihssi_rx_data_out_dly = din;
    bus8.rb_align_en           = en;
    bus8.rb_err_clr            = clr;
    hist.push_back(din);
    @(posedge clk);
    model_step(din, en, clr);
    #1;
    check_all();
  endtask

  function automatic logic [39:0] mk(input bit good);
    logic [39:0] w;
    w[31:0]  = $urandom;
    w[39:32] = 8'($urandom);
    w[39:38] = good ? 2'b10 : 2'b00;
    return w;
  endfunction

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_data"}, 64'(bus8.o_rx_data_aligned), 64'd0);
    chk({tag, "_vld"}, 64'(bus8.o_rx_data_vld), 64'd0);
    chk({tag, "_lock"}, 64'(bus8.o_align_lock), 64'd0);
    chk({tag, "_off"}, 64'(bus8.o_align_offset), 64'd0);
    chk({tag, "_err"}, 64'(bus8.o_mark_err_cnt), 64'd0);
  endtask

  initial begin
    logic [39:0] w, wp;
    bus8.ihssi_rx_data_out_dly = '0;
    bus8.rb_align_en           = 1'b0;
    bus8.rb_err_clr            = 1'b0;
    model_reset();
    #12;
    chk_zero_outputs("reset");
    rstn = 1'b1;

    // T1: aligned stream; bypass while the pipeline fills, then lock at offset 0
    for (int i = 0; i < 3; i++) step(mk(1'b1), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(mk(1'b1), 1'b1, 1'b0);
      if (i == 6) chk("t1_lock_pre", 64'(bus8.o_align_lock), 64'd0);
    end
    chk("t1_lock", 64'(bus8.o_align_lock), 64'd1);
    chk("t1_off", 64'(bus8.o_align_offset), 64'd0);
    chk("t1_vld", 64'(bus8.o_rx_data_vld), 64'd1);
    chk("t1_data", 64'(bus8.o_rx_data_aligned), 64'(hist[hist.size()-3]));

    // T3: single corrupted marker, then error clear
    step(mk(1'b0), 1'b1, 1'b0);
    step(mk(1'b1), 1'b1, 1'b0);
    step(mk(1'b1), 1'b1, 1'b0);
    chk("t3_err", 64'(bus8.o_mark_err_cnt), 64'd1);
    chk("t3_lock", 64'(bus8.o_align_lock), 64'd1);
    chk("t3_off", 64'(bus8.o_align_offset), 64'd0);
    step(mk(1'b1), 1'b1, 1'b1);
    chk("t3_clr", 64'(bus8.o_mark_err_cnt), 64'd0);

    // T4: four consecutive bad markers drop lock, clean stream relocks
    for (int i = 0; i < 4; i++) step(mk(1'b0), 1'b1, 1'b0);
    step(mk(1'b1), 1'b1, 1'b0);
    chk("t4_lock_3bad", 64'(bus8.o_align_lock), 64'd1);
    step(mk(1'b1), 1'b1, 1'b0);
    chk("t4_lock_4bad", 64'(bus8.o_align_lock), 64'd0);
    chk("t4_vld", 64'(bus8.o_rx_data_vld), 64'd0);
    for (int i = 0; i < 12; i++) step(mk(1'b1), 1'b1, 1'b0);
    chk("t4_relock", 64'(bus8.o_align_lock), 64'd1);
    step(mk(1'b0), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(mk(1'b1), 1'b1, 1'b0);
    chk("t5_err5", 64'(bus8.o_mark_err_cnt), 64'd5);
    chk("t5_sat_w2", 64'(bus2.o_mark_err_cnt), 64'd3);

    // T2: stream shifted by 13 bits; lock expected at offset 13 with original words recovered
    wp = mk(1'b1);
    for (int j = 0; j < 70; j++) begin
      w = mk(1'b1);
      orig.push_back(w);
      step({w[26:0], wp[39:27]}, (j >= 2), 1'b0);
      wp = w;
    end
    chk("t2_lock", 64'(bus8.o_align_lock), 64'd1);
    chk("t2_off", 64'(bus8.o_align_offset), 64'd13);
    chk("t2_data", 64'(bus8.o_rx_data_aligned), 64'(orig[orig.size()-3]));

    // T5: no marker anywhere, offset wraps 39 -> 0 and lock never asserts
    for (int i = 0; i < 2; i++) step('0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step('0, 1'b1, 1'b0);
      if (i == 38) chk("t5_off39", 64'(bus8.o_align_offset), 64'd39);
    end
    chk("t5_wrap", 64'(bus8.o_align_offset), 64'd0);
    chk("t5_nolock", 64'(bus8.o_align_lock), 64'd0);

    // Random phase: mostly good markers, occasional corruption, bypass and error clears
    for (int i = 0; i < 300; i++) begin
      step(mk(($urandom % 8) != 0), ($urandom % 40) != 0, ($urandom % 25) == 0);
    end

    // T6: asynchronous reset while locked, then bypass
    for (int i = 0; i < 2; i++) step(mk(1'b1), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(mk(1'b1), 1'b1, 1'b0);
    chk("t6_locked", 64'(bus8.o_align_lock), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk_zero_outputs("t6_rst");
    model_reset();
    #2;
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) step(mk(1'b1), 1'b0, 1'b0);
    chk("t6_byp_vld", 64'(bus8.o_rx_data_vld), 64'd1);
    chk("t6_byp_off", 64'(bus8.o_align_offset), 64'd0);
    chk("t6_byp_lock", 64'(bus8.o_align_lock), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
